// File: rtl/alu_seq_exec.sv
// alu_seq_exec: multi-cycle execute stage fed by the register file.
// Single-cycle ADD/SUB/AND/OR/XOR, shift-add MUL and restoring DIV (one bit
// per cycle), result returned with a one-cycle write-back strobe.
// Build option: define ALU_SEQ_DIV_EN to implement DIV (op 110); without it
// op 110 behaves exactly like the illegal op 111.
module alu_seq_exec #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic             dst,
    input  logic [WIDTH-1:0] operand_x,
    input  logic [WIDTH-1:0] operand_y,
    output logic             reg_read_x,
    output logic             reg_read_y,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_out,
    output logic [WIDTH-1:0] result_hi,
    output logic             reg_write_x,
    output logic             reg_write_y,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v
);

    typedef enum logic {IDLE, EXEC} state_t;
    typedef enum logic [2:0] {
        OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010, OP_OR  = 3'b011,
        OP_XOR = 3'b100, OP_MUL = 3'b101, OP_DIV = 3'b110, OP_ILL = 3'b111
    } op_t;

    state_t               state, state_next;
    op_t                  op_q;
    logic                 dst_q;
    logic [WIDTH-1:0]     x_q, y_q;
    logic [CNT_W-1:0]     cnt;
    // MUL: {partial product high, remaining multiplier}; DIV: {remainder, dividend/quotient}
    logic [2*WIDTH-1:0]   acc, acc_next;
    logic                 accept, is_iter, finish;
    logic [WIDTH:0]       add_sum, sub_diff, step_sum;
    logic [WIDTH-1:0]     res_lo, res_hi;
    logic                 res_c, res_v;
`ifdef ALU_SEQ_DIV_EN
    logic [WIDTH:0]       step_sh, step_diff;
`endif

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // Next-state logic: one EXEC visit per op, length set by finish
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = EXEC;
            EXEC:    if (finish) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs and register-file strobes
    always_comb begin
        busy        = (state == EXEC);
        accept      = start & ~busy;
        reg_read_x  = accept;
        reg_read_y  = accept;
        reg_write_x = done & ~dst_q;
        reg_write_y = done & dst_q;
    end

    // Iteration control: MUL and non-zero-divisor DIV take WIDTH cycles
    always_comb begin
        is_iter = (op_q == OP_MUL);
`ifdef ALU_SEQ_DIV_EN
        if (op_q == OP_DIV && y_q != '0) is_iter = 1'b1;
`endif
        finish = ~is_iter | (cnt == CNT_W'(WIDTH - 1));
    end

    // Arithmetic and one MUL/DIV iteration step
    always_comb begin
        add_sum  = {1'b0, x_q} + {1'b0, y_q};
        sub_diff = {1'b0, x_q} - {1'b0, y_q};
        step_sum = '0;
        acc_next = acc;
`ifdef ALU_SEQ_DIV_EN
        step_sh   = '0;
        step_diff = '0;
`endif
        if (op_q == OP_MUL) begin
            step_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, x_q} : '0);
            acc_next = {step_sum, acc[WIDTH-1:1]};
        end
`ifdef ALU_SEQ_DIV_EN
        else if (op_q == OP_DIV) begin
            step_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
            step_diff = step_sh - {1'b0, y_q};
            if (!step_diff[WIDTH]) acc_next = {step_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            else                   acc_next = {step_sh[WIDTH-1:0],   acc[WIDTH-2:0], 1'b0};
        end
`endif
    end

    // Final result and carry/overflow selection
    always_comb begin
        res_lo = '0;
        res_hi = '0;
        res_c  = 1'b0;
        res_v  = 1'b0;
        case (op_q)
            OP_ADD: begin
                res_lo = add_sum[WIDTH-1:0];
                res_c  = add_sum[WIDTH];
                res_v  = (x_q[WIDTH-1] == y_q[WIDTH-1]) && (add_sum[WIDTH-1] != x_q[WIDTH-1]);
            end
            OP_SUB: begin
                res_lo = sub_diff[WIDTH-1:0];
                res_c  = sub_diff[WIDTH];
                res_v  = (x_q[WIDTH-1] != y_q[WIDTH-1]) && (sub_diff[WIDTH-1] != x_q[WIDTH-1]);
            end
            OP_AND: res_lo = x_q & y_q;
            OP_OR:  res_lo = x_q | y_q;
            OP_XOR: res_lo = x_q ^ y_q;
            OP_MUL: begin
                res_lo = acc_next[WIDTH-1:0];
                res_hi = acc_next[2*WIDTH-1:WIDTH];
                res_c  = |acc_next[2*WIDTH-1:WIDTH];
            end
`ifdef ALU_SEQ_DIV_EN
            OP_DIV: begin
                if (y_q == '0) begin
                    res_lo = '1;
                    res_hi = x_q;
                    res_c  = 1'b1;
                end else begin
                    res_lo = acc_next[WIDTH-1:0];
                    res_hi = acc_next[2*WIDTH-1:WIDTH];
                end
            end
`endif
            default: begin
                res_c = 1'b1;
                res_v = 1'b1;
            end
        endcase
    end

    // Operand capture, iteration state and registered results
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q       <= OP_ADD;
            dst_q      <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            cnt        <= '0;
            acc        <= '0;
            done       <= 1'b0;
            result_out <= '0;
            result_hi  <= '0;
            flag_z     <= 1'b0;
            flag_n     <= 1'b0;
            flag_c     <= 1'b0;
            flag_v     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                op_q  <= op_t'(op);
                dst_q <= dst;
                x_q   <= operand_x;
                y_q   <= operand_y;
                cnt   <= '0;
                if (op == OP_MUL) acc <= {{WIDTH{1'b0}}, operand_y};
                else              acc <= {{WIDTH{1'b0}}, operand_x};
            end else if (state == EXEC) begin
                if (finish) begin
                    done       <= 1'b1;
                    result_out <= res_lo;
                    result_hi  <= res_hi;
                    flag_z     <= (res_lo == '0);
                    flag_n     <= res_lo[WIDTH-1];
                    flag_c     <= res_c;
                    flag_v     <= res_v;
                end else begin
                    acc <= acc_next;
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_seq_exec.sv
// Testbench for alu_seq_exec (WIDTH=16): scoreboard of expected results
// produced by a plain-arithmetic reference model, checked by a monitor
// whenever the expected done cycle arrives. Honours ALU_SEQ_DIV_EN.
module tb_alu_seq_exec;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic        dst = 1'b0;
    logic [15:0] operand_x = '0;
    logic [15:0] operand_y = '0;
    logic        reg_read_x, reg_read_y, busy, done;
    logic [15:0] result_out, result_hi;
    logic        reg_write_x, reg_write_y, flag_z, flag_n, flag_c, flag_v;

    alu_seq_exec #(.WIDTH(16), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .dst(dst),
        .operand_x(operand_x), .operand_y(operand_y),
        .reg_read_x(reg_read_x), .reg_read_y(reg_read_y),
        .busy(busy), .done(done),
        .result_out(result_out), .result_hi(result_hi),
        .reg_write_x(reg_write_x), .reg_write_y(reg_write_y),
        .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .flag_v(flag_v)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          done_cyc;
        int          lat;
        logic [15:0] lo;
        logic [15:0] hi;
        logic        z, n, c, v;
        logic        d;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   next_free = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Reference model straight from the operation definitions
    function automatic exp_t model(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                                   input logic d);
        exp_t e;
        int unsigned ua, ub, r;
        int sa, sy, sr;
        ua = a; ub = b;
        sa = $signed(a); sy = $signed(b);
        e.lat = 1; e.lo = '0; e.hi = '0; e.c = 1'b0; e.v = 1'b0; e.d = d; e.done_cyc = 0;
        r = 0; sr = 0;
        case (o)
            3'd0: begin
                r = ua + ub; e.lo = r[15:0]; e.c = (r > 65535);
                sr = sa + sy; e.v = (sr > 32767) || (sr < -32768);
            end
            3'd1: begin
                r = ua - ub; e.lo = r[15:0]; e.c = (ua < ub);
                sr = sa - sy; e.v = (sr > 32767) || (sr < -32768);
            end
            3'd2: e.lo = a & b;
            3'd3: e.lo = a | b;
            3'd4: e.lo = a ^ b;
            3'd5: begin
                r = ua * ub; e.lo = r[15:0]; e.hi = r[31:16]; e.c = (e.hi != 0); e.lat = 16;
            end
`ifdef ALU_SEQ_DIV_EN
            3'd6: begin
                if (ub == 0) begin
                    e.lo = 16'hFFFF; e.hi = a; e.c = 1'b1;
                end else begin
                    r = ua / ub; e.lo = r[15:0];
                    r = ua % ub; e.hi = r[15:0];
                    e.lat = 16;
                end
            end
`endif
            default: begin e.c = 1'b1; e.v = 1'b1; end
        endcase
        e.z = (e.lo == 0);
        e.n = e.lo[15];
        return e;
    endfunction

    // One clock of stimulus; predicts acceptance and queues the expected result
    task automatic drive_cycle(input bit s, input logic [2:0] o, input logic [15:0] a,
                               input logic [15:0] b, input logic d, output bit acc);
        exp_t e;
        bit exp_busy;
        @(negedge clk);
        start = s; op = o; operand_x = a; operand_y = b; dst = d;
        #1;
        exp_busy = (cyc + 1 < next_free);
        acc = s && !exp_busy;
        check("busy", 64'(busy), 64'(exp_busy));
        check("reg_read", 64'({reg_read_x, reg_read_y}), 64'({acc, acc}));
        if (acc) begin
            e = model(o, a, b, d);
            e.done_cyc = cyc + 1 + e.lat;
            next_free = e.done_cyc + 1;
            sb.push_back(e);
        end
    endtask

    task automatic send_op(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                           input logic d);
        bit acc;
        acc = 1'b0;
        for (int i = 0; i < 40 && !acc; i++) drive_cycle(1'b1, o, a, b, d, acc);
        check("accept_timeout", 64'(acc), 64'(1));
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++)
            drive_cycle(1'b0, 3'($urandom), 16'($urandom), 16'($urandom), 1'($urandom), acc);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        start = 1'b0;
        #2;
        rst = 1'b0;
        sb.delete();
        next_free = 0;
        #1;
        check("reset_state",
              64'({busy, done, reg_read_x, reg_read_y, reg_write_x, reg_write_y,
                   flag_z, flag_n, flag_c, flag_v, result_out, result_hi}), 64'(0));
        repeat (n) @(negedge clk);
        #2;
        rst = 1'b1;
    endtask

    // Monitor: compares at the predicted done cycle, flags any other done
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (sb.size() > 0 && sb[0].done_cyc == cyc) begin
                    e = sb.pop_front();
                    check("done", 64'(done), 64'(1));
                    check("result", 64'({result_hi, result_out}), 64'({e.hi, e.lo}));
                    check("flags", 64'({flag_z, flag_n, flag_c, flag_v}), 64'({e.z, e.n, e.c, e.v}));
                    check("write_strobes", 64'({reg_write_x, reg_write_y}), 64'({~e.d, e.d}));
                end else begin
                    check("no_done", 64'(done), 64'(0));
                end
            end
        end
    end

    initial begin
        logic [2:0]  o;
        logic [15:0] a, b;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        do_reset(2);

        send_op(3'd0, 16'h7FFF, 16'h0001, 1'b0);
        idle(2);
        send_op(3'd1, 16'h0003, 16'h0005, 1'b1);
        send_op(3'd4, 16'hA5A5, 16'hA5A5, 1'b0);
        idle(1);
        // MUL, then a start held during the whole op must be ignored
        send_op(3'd5, 16'hFFFF, 16'hFFFF, 1'b1);
        send_op(3'd2, 16'h1234, 16'h00FF, 1'b0);
        idle(2);
        send_op(3'd6, 16'hA5A5, 16'h0010, 1'b0);
        send_op(3'd6, 16'hA5A5, 16'h0000, 1'b1);
        send_op(3'd7, 16'h1111, 16'h2222, 1'b0);
        idle(2);
        // back-to-back: second op taken in the first op's done cycle
        send_op(3'd0, 16'h0102, 16'h0304, 1'b0);
        send_op(3'd2, 16'hF0F0, 16'h3C3C, 1'b1);
        idle(3);

        // abort a MUL partway through; no done may follow
        send_op(3'd5, 16'h1234, 16'h5678, 1'b0);
        idle(4);
        do_reset(2);
        idle(24);

        for (int i = 0; i < 150; i++) begin
            o = 3'($urandom_range(0, 7));
            a = 16'($urandom);
            case ($urandom_range(0, 4))
                0:       b = 16'd0;
                1:       b = 16'($urandom_range(1, 40));
                default: b = 16'($urandom);
            endcase
            send_op(o, a, b, 1'($urandom));
            idle($urandom_range(0, 2));
        end

        for (int i = 0; i < 60 && sb.size() > 0; i++) idle(1);
        check("scoreboard_drained", 64'(sb.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
